// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-side initiator for the instruction memory.
// Holds the program counter and drives the word address into IM.
// Selects the next PC from four sources: sequential, beq-style branch,
// j/jal and jr. It also produces the jal link address and counts PC advances.
// An illegal fetch target puts the unit into a sticky halt. Only reset
// clears the halt.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   stall      in   hold PC, counter and error flag this cycle
//   npc_sel    in   2  next-PC source: 00 seq, 01 branch, 10 jump, 11 jr
//   br_taken   in   1  branch condition, used only with npc_sel=01
//   imm16      in   16 signed branch offset in words
//   imm26      in   26 jump index
//   jr_target  in   32 register value for jr
//   addr       out  32 current PC, registered
//   pc4        out  32 addr + 4
//   link_addr  out  32 jal return address (== pc4)
//   addr_err   out  1  sticky illegal-target flag (HALT state)
//   fetch_cnt  out  32 PC advances since reset, wraps modulo 2^32
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] jr_target,
  output logic [31:0] addr,
  output logic [31:0] pc4,
  output logic [31:0] link_addr,
  output logic        addr_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  // Window bounds carried at 33 bits, so RESET_PC + 4*IM_WORDS cannot wrap.
  localparam logic [32:0] WIN_LO = {1'b0, RESET_PC};
  localparam logic [32:0] WIN_HI = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] npc;
  logic [31:0] br_off;
  logic        npc_legal;

  assign pc4       = pc_q + 32'd4;
  assign link_addr = pc4;
  assign addr      = pc_q;
  assign addr_err  = (state_q == HALT);
  assign fetch_cnt = cnt_q;

  // Word offset, sign-extended and scaled to bytes.
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    npc = pc4;
    unique case (npc_sel)
      2'b00: npc = pc4;
      2'b01: npc = br_taken ? pc4 + br_off : pc4;
      2'b10: npc = {pc_q[31:28], imm26, 2'b00};
      2'b11: npc = jr_target;
      default: npc = pc4;
    endcase
  end

  assign npc_legal = (npc[1:0] == 2'b00) &&
                     ({1'b0, npc} >= WIN_LO) &&
                     ({1'b0, npc} <  WIN_HI);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    // HALT freezes everything. Only reset leaves it.
    if (!stall && state_q == RUN) begin
      if (npc_legal) begin
        pc_d  = npc;
        cnt_d = cnt_q + 32'd1;
      end else begin
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit. The driver applies one input set per
// cycle at the falling edge. It advances a behavioural model and queues the
// state expected after the next rising edge. A monitor pops one entry after
// every rising edge and compares it with the DUT outputs.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          IM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken;
  logic [1:0]  npc_sel;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] jr_target;
  logic [31:0] addr, pc4, link_addr, fetch_cnt;
  logic        addr_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_err;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
    .br_taken(br_taken), .imm16(imm16), .imm26(imm26), .jr_target(jr_target),
    .addr(addr), .pc4(pc4), .link_addr(link_addr), .addr_err(addr_err),
    .fetch_cnt(fetch_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // The model works from the rules in plain integer arithmetic.
  task automatic drive(input logic r, input logic st, input logic [1:0] sel,
                       input logic br, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] jt);
    longint tgt;
    exp_t   e;
    @(negedge clk);
    reset = r; stall = st; npc_sel = sel; br_taken = br;
    imm16 = i16; imm26 = i26; jr_target = jt;
    if (r) begin
      m_pc = RESET_PC; m_cnt = 0; m_err = 1'b0;
    end else if (!st && !m_err) begin
      case (sel)
        2'd0: tgt = longint'(m_pc) + 4;
        2'd1: tgt = br ? longint'(m_pc) + 4 + longint'($signed(i16)) * 4
                       : longint'(m_pc) + 4;
        2'd2: tgt = (longint'(m_pc) / 268435456) * 268435456 + longint'(i26) * 4;
        default: tgt = longint'(jt);
      endcase
      tgt = tgt % 64'sh1_0000_0000;
      if (tgt < 0) tgt = tgt + 64'sh1_0000_0000;
      if (tgt % 4 == 0 && tgt >= longint'(RESET_PC) &&
          tgt < longint'(RESET_PC) + 4 * IM_WORDS) begin
        m_pc  = 32'(tgt);
        m_cnt = m_cnt + 1;
      end else begin
        m_err = 1'b1;
      end
    end
    e.addr = m_pc; e.cnt = m_cnt; e.err = m_err;
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents a new state after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("addr",      addr,      e.addr);
      chk("pc4",       pc4,       e.addr + 32'd4);
      chk("link_addr", link_addr, e.addr + 32'd4);
      chk("fetch_cnt", fetch_cnt, e.cnt);
      chk("addr_err",  {31'd0, addr_err}, {31'd0, e.err});
    end
  end

  initial begin
    logic        r, st, br;
    logic [1:0]  sel;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] jt;
    int          wait_cyc;

    reset = 1'b1; stall = 1'b0; npc_sel = 2'd0; br_taken = 1'b0;
    imm16 = 16'd0; imm26 = 26'd0; jr_target = 32'd0;

    // Sequential flow, then branches from 0x3010.
    drive(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    repeat (4) drive(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    drive(0, 0, 2'd1, 1, 16'hFFFC, 26'h0, 32'h0);  // -> 0x3004
    drive(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    repeat (4) drive(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    drive(0, 0, 2'd1, 0, 16'hFFFC, 26'h0, 32'h0);  // not taken -> 0x3014

    // Jump and jr.
    drive(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    drive(0, 0, 2'd2, 0, 16'h0, 26'h0000C40, 32'h0);  // -> 0x3100
    drive(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3020);
    // Stalled jump holds, then the jump is taken.
    repeat (3) drive(0, 1, 2'd2, 0, 16'h0, 26'h0000C40, 32'h0);
    drive(0, 0, 2'd2, 0, 16'h0, 26'h0000C40, 32'h0);

    // Misaligned jr halts. Later legal redirects are ignored.
    drive(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3002);
    drive(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3020);
    drive(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    drive(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    // One past the window halts.
    drive(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h4000);
    drive(0, 0, 2'd2, 0, 16'h0, 26'h0000C40, 32'h0);
    drive(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    // Last word of the window is legal, and stepping past it halts.
    drive(0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3FFC);
    drive(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    // Below the window.
    drive(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    drive(0, 0, 2'd1, 1, 16'hFFFF, 26'h0, 32'h0);  // 0x3000 -> 0x3000 legal
    drive(0, 0, 2'd1, 1, 16'hFFFE, 26'h0, 32'h0);  // -> 0x2FFC illegal
    // Reset wins over stall.
    drive(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0);
    drive(0, 0, 2'd2, 0, 16'h0, 26'h0000C40, 32'h0);
    drive(1, 1, 2'd2, 0, 16'h0, 26'h0000C40, 32'h0);

    // Randomised traffic, biased toward in-window targets.
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 99) < 3) || (m_err && $urandom_range(0, 7) == 0);
      st  = ($urandom_range(0, 99) < 20);
      sel = 2'($urandom_range(0, 3));
      br  = 1'($urandom_range(0, 1));
      i16 = 16'($urandom_range(0, 63)) - 16'd32;
      if ($urandom_range(0, 15) == 0) i16 = 16'($urandom);
      i26 = 26'h0000C00 + 26'($urandom_range(0, 1023));
      if ($urandom_range(0, 15) == 0) i26 = 26'($urandom);
      jt  = RESET_PC + 32'($urandom_range(0, IM_WORDS - 1)) * 4;
      if ($urandom_range(0, 15) == 0) jt = $urandom;
      drive(r, st, sel, br, i16, i26, jt);
    end

    // Let the monitor drain the queue. A bounded wait keeps the bench from hanging.
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
